// File: rtl/vga_fill_engine.sv
// Rectangle-fill engine feeding the VGA video-memory write port; CPU direct writes pass through with priority.
// Optional: define VGA_FILL_ABORT_EN to enable CTRL bit1 abort and the sticky aborted flag (CTRL read bit2).
module vga_fill_engine #(
  parameter int          screen_length   = 400,
  parameter int          screen_width    = 300,
  parameter int          X_WIDTH         = 11,
  parameter int          Y_WIDTH         = 11,
  parameter int          VMEM_ADDR_WIDTH = 32,
  parameter int unsigned VMEM_BASE       = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_w_en,
  input  logic [1:0]                 cfg_addr,
  input  logic [31:0]                cfg_w_data,
  output logic [31:0]                cfg_r_data,
  input  logic                       cpu_w_en,
  input  logic [VMEM_ADDR_WIDTH-1:0] cpu_w_addr,
  input  logic [3:0]                 cpu_w_byte_en,
  input  logic [31:0]                cpu_w_data,
  output logic                       vga_w_en,
  output logic [VMEM_ADDR_WIDTH-1:0] vga_w_addr,
  output logic [3:0]                 vga_w_byte_en,
  output logic [31:0]                vga_w_data,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [X_WIDTH:0]         SCR_L     = (X_WIDTH+1)'(screen_length);
  localparam logic [Y_WIDTH:0]         SCR_W     = (Y_WIDTH+1)'(screen_width);
  localparam logic [X_WIDTH:0]         X_ONE     = (X_WIDTH+1)'(1);
  localparam logic [Y_WIDTH:0]         Y_ONE     = (Y_WIDTH+1)'(1);
  localparam logic [VMEM_ADDR_WIDTH-1:0] ROW_BYTES = VMEM_ADDR_WIDTH'(screen_length * 2);
  localparam logic [VMEM_ADDR_WIDTH-1:0] BASE      = VMEM_ADDR_WIDTH'(VMEM_BASE);

  state_t state_q, state_d;

  logic [X_WIDTH-1:0] org_x_q, size_w_q;
  logic [Y_WIDTH-1:0] org_y_q, size_h_q;
  logic [11:0]        color_q, color_run_q;

  logic [X_WIDTH:0]   xs_q, xe_q, x_q, x_sum;
  logic [Y_WIDTH:0]   ye_q, y_q, y_sum;
  logic [VMEM_ADDR_WIDTH-1:0] row_base_q;

  logic start_req, start_go, abort_req, rect_empty;
  logic last_col, last_pix;
  logic sticky_done_q, aborted_q, done_q;

  logic                       vld_p0;
  logic [VMEM_ADDR_WIDTH-1:0] pix_addr_p0;
  logic [3:0]                 pix_be_p0;
  logic [31:0]                pix_data_p0;

  logic unused_cfg;
  assign unused_cfg = &{1'b0, cfg_w_data};

  function automatic logic [X_WIDTH:0] sat_x(input logic [X_WIDTH:0] v);
    return (v > SCR_L) ? SCR_L : v;
  endfunction

  function automatic logic [Y_WIDTH:0] sat_y(input logic [Y_WIDTH:0] v);
    return (v > SCR_W) ? SCR_W : v;
  endfunction

  // Register file; geometry writes during a fill only touch these, never the working copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      org_x_q  <= '0;
      org_y_q  <= '0;
      size_w_q <= '0;
      size_h_q <= '0;
      color_q  <= '0;
    end else if (cfg_w_en) begin
      case (cfg_addr)
        2'd0: begin
          org_x_q <= cfg_w_data[X_WIDTH-1:0];
          org_y_q <= cfg_w_data[Y_WIDTH+15:16];
        end
        2'd1: begin
          size_w_q <= cfg_w_data[X_WIDTH-1:0];
          size_h_q <= cfg_w_data[Y_WIDTH+15:16];
        end
        2'd2:    color_q <= cfg_w_data[11:0];
        default: ;
      endcase
    end
  end

  assign start_req = cfg_w_en && (cfg_addr == 2'd3) && cfg_w_data[0];
  assign start_go  = (state_q == IDLE) && start_req;

`ifdef VGA_FILL_ABORT_EN
  assign abort_req = cfg_w_en && (cfg_addr == 2'd3) && cfg_w_data[1] && (state_q == RUN);

  always_ff @(posedge clk) begin
    if (reset)          aborted_q <= 1'b0;
    else if (start_go)  aborted_q <= 1'b0;
    else if (abort_req) aborted_q <= 1'b1;
  end
`else
  assign abort_req = 1'b0;
  assign aborted_q = 1'b0;
`endif

  // Sums are one bit wider than the fields so clipping never sees a wrapped end coordinate.
  assign x_sum      = {1'b0, org_x_q} + {1'b0, size_w_q};
  assign y_sum      = {1'b0, org_y_q} + {1'b0, size_h_q};
  assign rect_empty = (size_w_q == '0) || (size_h_q == '0) ||
                      ({1'b0, org_x_q} >= SCR_L) || ({1'b0, org_y_q} >= SCR_W);

  assign last_col = (x_q == xe_q - X_ONE);
  assign last_pix = last_col && (y_q == ye_q - Y_ONE);

  // p0: pixel generation; stalls whenever the CPU owns the write port.
  assign vld_p0      = (state_q == RUN) && !cpu_w_en && !abort_req;
  assign pix_addr_p0 = row_base_q + VMEM_ADDR_WIDTH'({x_q, 1'b0});
  assign pix_be_p0   = x_q[0] ? 4'b1100 : 4'b0011;
  assign pix_data_p0 = x_q[0] ? {4'b0, color_run_q, 16'b0} : {20'b0, color_run_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = rect_empty ? DONE : RUN;
      RUN:     if (abort_req || (vld_p0 && last_pix)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Working copies: row base steps by one row with an adder, never a runtime multiply.
  always_ff @(posedge clk) begin
    if (start_go) begin
      xs_q        <= {1'b0, org_x_q};
      x_q         <= {1'b0, org_x_q};
      y_q         <= {1'b0, org_y_q};
      xe_q        <= sat_x(x_sum);
      ye_q        <= sat_y(y_sum);
      row_base_q  <= BASE + VMEM_ADDR_WIDTH'(org_y_q) * ROW_BYTES;
      color_run_q <= color_q;
    end else if (vld_p0) begin
      if (last_col) begin
        x_q        <= xs_q;
        y_q        <= y_q + Y_ONE;
        row_base_q <= row_base_q + ROW_BYTES;
      end else begin
        x_q <= x_q + X_ONE;
      end
    end
  end

  // p1: registered write port; CPU writes take absolute priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_w_en      <= 1'b0;
      vga_w_addr    <= '0;
      vga_w_byte_en <= '0;
      vga_w_data    <= '0;
    end else if (cpu_w_en) begin
      vga_w_en      <= 1'b1;
      vga_w_addr    <= cpu_w_addr;
      vga_w_byte_en <= cpu_w_byte_en;
      vga_w_data    <= cpu_w_data;
    end else if (vld_p0) begin
      vga_w_en      <= 1'b1;
      vga_w_addr    <= pix_addr_p0;
      vga_w_byte_en <= pix_be_p0;
      vga_w_data    <= pix_data_p0;
    end else begin
      vga_w_en <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q        <= 1'b0;
      sticky_done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (start_go)                sticky_done_q <= 1'b0;
      else if (state_q == DONE)    sticky_done_q <= 1'b1;
    end
  end

  assign done = done_q;
  assign busy = (state_q == RUN);

  always_comb begin
    cfg_r_data = '0;
    case (cfg_addr)
      2'd0: begin
        cfg_r_data[X_WIDTH-1:0]     = org_x_q;
        cfg_r_data[Y_WIDTH+15:16]   = org_y_q;
      end
      2'd1: begin
        cfg_r_data[X_WIDTH-1:0]     = size_w_q;
        cfg_r_data[Y_WIDTH+15:16]   = size_h_q;
      end
      2'd2:    cfg_r_data[11:0] = color_q;
      default: cfg_r_data[2:0]  = {aborted_q, sticky_done_q, busy};
    endcase
  end

endmodule

// File: tb/tb_vga_fill_engine.sv
// Self-checking bench for vga_fill_engine: directed scenarios plus randomized fills against a pixel-list model.
module tb_vga_fill_engine;
  localparam int SL = 400;
  localparam int SW = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_w_en = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_w_data = '0;
  logic [31:0] cfg_r_data;
  logic        cpu_w_en = 1'b0;
  logic [31:0] cpu_w_addr = '0;
  logic [3:0]  cpu_w_byte_en = '0;
  logic [31:0] cpu_w_data = '0;
  logic        vga_w_en;
  logic [31:0] vga_w_addr;
  logic [3:0]  vga_w_byte_en;
  logic [31:0] vga_w_data;
  logic        busy, done;

  vga_fill_engine dut (
    .clk(clk), .reset(reset),
    .cfg_w_en(cfg_w_en), .cfg_addr(cfg_addr), .cfg_w_data(cfg_w_data), .cfg_r_data(cfg_r_data),
    .cpu_w_en(cpu_w_en), .cpu_w_addr(cpu_w_addr), .cpu_w_byte_en(cpu_w_byte_en), .cpu_w_data(cpu_w_data),
    .vga_w_en(vga_w_en), .vga_w_addr(vga_w_addr), .vga_w_byte_en(vga_w_byte_en), .vga_w_data(vga_w_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic cpu_d = 1'b0;

  logic [67:0] obs_fill[$];
  logic [67:0] obs_cpu[$];
  logic [67:0] exp_fill[$];
  logic [67:0] exp_cpu[$];
  int done_cnt = 0, done_cyc = -1, first_w_cyc = -1, busy_cnt = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    cpu_d <= cpu_w_en;
  end

  // A write seen on the port is a CPU write exactly when the bench drove cpu_w_en on the loading edge.
  always @(negedge clk) begin
    if (vga_w_en) begin
      if (cpu_d) obs_cpu.push_back({vga_w_addr, vga_w_byte_en, vga_w_data});
      else begin
        obs_fill.push_back({vga_w_addr, vga_w_byte_en, vga_w_data});
        if (first_w_cyc < 0) first_w_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_fill.delete(); obs_cpu.delete(); exp_cpu.delete();
    done_cnt = 0; done_cyc = -1; first_w_cyc = -1; busy_cnt = 0;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    step();
    cfg_w_en = 1'b1; cfg_addr = a; cfg_w_data = d;
    step();
    cfg_w_en = 1'b0;
  endtask

  task automatic program_rect(input int x, input int y, input int w, input int h, input logic [11:0] col);
    cfg_wr(2'd0, 32'((y << 16) | x));
    cfg_wr(2'd1, 32'((h << 16) | w));
    cfg_wr(2'd2, {20'b0, col});
  endtask

  task automatic start_fill(output int scyc);
    step();
    cfg_w_en = 1'b1; cfg_addr = 2'd3; cfg_w_data = 32'd1; scyc = cyc;
    step();
    cfg_w_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin ok = 1'b1; break; end
      step();
    end
    if (done_cnt > 0) ok = 1'b1;
  endtask

  // Reference: every on-screen pixel of the rectangle, row-major, as {addr, byte_en, data}.
  task automatic build_exp(input int x0, input int y0, input int w, input int h, input logic [11:0] col);
    int xe, ye;
    exp_fill.delete();
    xe = (x0 + w > SL) ? SL : x0 + w;
    ye = (y0 + h > SW) ? SW : y0 + h;
    for (int y = y0; y < ye; y++)
      for (int x = x0; x < xe; x++) begin
        if (x % 2 == 0) exp_fill.push_back({32'(2 * (y * SL + x)), 4'b0011, 20'b0, col});
        else            exp_fill.push_back({32'(2 * (y * SL + x)), 4'b1100, 4'b0, col, 16'b0});
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    n_cmp++;
    if ({vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%h be=%b data=%h busy=%b done=%b, required all 0",
               vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data, busy, done);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      n_cmp++;
      if (cfg_r_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 00000000", a, cfg_r_data);
      end
    end
  endtask

  task automatic test_basic();
    int s; bit ok;
    program_rect(2, 1, 3, 2, 12'hABC);
    build_exp(2, 1, 3, 2, 12'hABC);
    clear_obs();
    start_fill(s);
    n_cmp++;
    if (cfg_r_data[0] !== 1'b1) begin
      n_fail++; $display("FAIL basic_ctrl_busy: got %b, required 1", cfg_r_data[0]);
    end
    wait_done(100, ok);
    repeat (3) step();
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: done never seen, required 1 pulse"); end
    n_cmp++;
    if (obs_fill.size() !== 6) begin
      n_fail++; $display("FAIL basic_count: got %0d writes, required 6", obs_fill.size());
    end
    for (int i = 0; i < exp_fill.size() && i < obs_fill.size(); i++) begin
      n_cmp++;
      if (obs_fill[i] !== exp_fill[i]) begin
        n_fail++; $display("FAIL basic_pix[%0d]: got %h, required %h", i, obs_fill[i], exp_fill[i]);
      end
    end
    n_cmp++;
    if (obs_fill.size() > 0 && obs_fill[0] !== {32'd804, 4'b0011, 32'h00000ABC}) begin
      n_fail++; $display("FAIL basic_first: got %h, required addr 804 be 0011 data 00000abc", obs_fill[0]);
    end
    n_cmp++;
    if (first_w_cyc - s !== 2) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles, required 2", first_w_cyc - s);
    end
    n_cmp++;
    if (busy_cnt !== 6) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d, required 6", busy_cnt);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc - s !== 8) begin
      n_fail++; $display("FAIL basic_done: got %0d pulses at +%0d, required 1 at +8", done_cnt, done_cyc - s);
    end
    cfg_addr = 2'd3; #1;
    n_cmp++;
    if (cfg_r_data[2:0] !== 3'b010) begin
      n_fail++; $display("FAIL basic_ctrl_after: got %b, required 010", cfg_r_data[2:0]);
    end
  endtask

  task automatic test_empty();
    int s; bit ok;
    // Zero width, then an origin past the right edge.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) program_rect(5, 5, 0, 5, 12'h123);
      else        program_rect(SL, 0, 3, 3, 12'h123);
      clear_obs();
      start_fill(s);
      wait_done(20, ok);
      repeat (3) step();
      n_cmp++;
      if (!ok || obs_fill.size() !== 0 || done_cnt !== 1 || done_cyc - s !== 2) begin
        n_fail++;
        $display("FAIL empty%0d: got %0d writes, %0d done pulses at +%0d, required 0 writes, 1 pulse at +2",
                 k, obs_fill.size(), done_cnt, done_cyc - s);
      end
      cfg_addr = 2'd3; #1;
      n_cmp++;
      if (cfg_r_data[1] !== 1'b1) begin
        n_fail++; $display("FAIL empty%0d_sticky: got %b, required 1", k, cfg_r_data[1]);
      end
    end
  endtask

  task automatic test_clip();
    int s; bit ok;
    logic [11:0] col;
    col = 12'($urandom);
    program_rect(398, 299, 10, 10, col);
    build_exp(398, 299, 10, 10, col);
    clear_obs();
    start_fill(s);
    n_cmp++;
    if (cfg_r_data[1:0] !== 2'b01) begin
      n_fail++; $display("FAIL clip_sticky_cleared: got %b, required 01", cfg_r_data[1:0]);
    end
    wait_done(50, ok);
    repeat (2) step();
    n_cmp++;
    if (!ok || obs_fill.size() !== 2 || done_cnt !== 1) begin
      n_fail++; $display("FAIL clip_count: got %0d writes, %0d done, required 2 writes, 1 done", obs_fill.size(), done_cnt);
    end
    for (int i = 0; i < exp_fill.size() && i < obs_fill.size(); i++) begin
      n_cmp++;
      if (obs_fill[i] !== exp_fill[i]) begin
        n_fail++; $display("FAIL clip_pix[%0d]: got %h, required %h", i, obs_fill[i], exp_fill[i]);
      end
    end
    n_cmp++;
    if (obs_fill.size() == 2 && (obs_fill[0][67:36] !== 32'd239996 || obs_fill[1][67:36] !== 32'd239998)) begin
      n_fail++; $display("FAIL clip_addr: got %0d,%0d, required 239996,239998", obs_fill[0][67:36], obs_fill[1][67:36]);
    end
  endtask

  task automatic test_stall();
    int s; bit ok; bit seen;
    logic [11:0] col;
    col = 12'($urandom);
    program_rect(10, 20, 4, 1, col);
    build_exp(10, 20, 4, 1, col);
    clear_obs();
    start_fill(s);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (obs_fill.size() >= 2) begin seen = 1'b1; break; end
      step();
    end
    for (int c = 0; c < 2; c++) begin
      cpu_w_en = 1'b1; cpu_w_addr = $urandom; cpu_w_byte_en = 4'($urandom); cpu_w_data = $urandom;
      exp_cpu.push_back({cpu_w_addr, cpu_w_byte_en, cpu_w_data});
      step();
    end
    cpu_w_en = 1'b0;
    wait_done(50, ok);
    repeat (2) step();
    n_cmp++;
    if (!seen || !ok || obs_fill.size() !== 4 || obs_cpu.size() !== 2) begin
      n_fail++; $display("FAIL stall_count: got %0d fill / %0d cpu writes, required 4 / 2", obs_fill.size(), obs_cpu.size());
    end
    for (int i = 0; i < exp_fill.size() && i < obs_fill.size(); i++) begin
      n_cmp++;
      if (obs_fill[i] !== exp_fill[i]) begin
        n_fail++; $display("FAIL stall_pix[%0d]: got %h, required %h", i, obs_fill[i], exp_fill[i]);
      end
    end
    for (int i = 0; i < exp_cpu.size() && i < obs_cpu.size(); i++) begin
      n_cmp++;
      if (obs_cpu[i] !== exp_cpu[i]) begin
        n_fail++; $display("FAIL stall_cpu[%0d]: got %h, required %h", i, obs_cpu[i], exp_cpu[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s; bit ok;
    program_rect(0, 0, 5, 3, 12'h5A5);
    clear_obs();
    start_fill(s);
    for (int i = 0; i < 20; i++) begin
      if (obs_fill.size() >= 4) break;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got en=%b addr=%h be=%b data=%h busy=%b done=%b, required all 0",
               vga_w_en, vga_w_addr, vga_w_byte_en, vga_w_data, busy, done);
    end
    step();
    cfg_addr = 2'd3; #1;
    n_cmp++;
    if (busy !== 1'b0 || vga_w_en !== 1'b0 || cfg_r_data !== 32'd0) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%b en=%b ctrl=%h, required 0 0 0", busy, vga_w_en, cfg_r_data);
    end
    program_rect(7, 2, 3, 2, 12'h0F0);
    build_exp(7, 2, 3, 2, 12'h0F0);
    clear_obs();
    start_fill(s);
    wait_done(50, ok);
    repeat (2) step();
    n_cmp++;
    if (!ok || obs_fill.size() !== exp_fill.size() || done_cnt !== 1) begin
      n_fail++; $display("FAIL midreset_refill: got %0d writes, %0d done, required %0d writes, 1 done",
                         obs_fill.size(), done_cnt, exp_fill.size());
    end
    for (int i = 0; i < exp_fill.size() && i < obs_fill.size(); i++) begin
      n_cmp++;
      if (obs_fill[i] !== exp_fill[i]) begin
        n_fail++; $display("FAIL midreset_pix[%0d]: got %h, required %h", i, obs_fill[i], exp_fill[i]);
      end
    end
  endtask

`ifdef VGA_FILL_ABORT_EN
  task automatic test_abort();
    int s; bit ok;
    program_rect(20, 5, 10, 1, 12'h321);
    build_exp(20, 5, 10, 1, 12'h321);
    clear_obs();
    start_fill(s);
    for (int i = 0; i < 20; i++) begin
      if (obs_fill.size() >= 3) break;
      step();
    end
    cfg_w_en = 1'b1; cfg_addr = 2'd3; cfg_w_data = 32'd2;
    step();
    cfg_w_en = 1'b0;
    wait_done(20, ok);
    repeat (3) step();
    n_cmp++;
    if (!ok || obs_fill.size() !== 3 || done_cnt !== 1) begin
      n_fail++; $display("FAIL abort_count: got %0d writes, %0d done, required 3 writes, 1 done", obs_fill.size(), done_cnt);
    end
    for (int i = 0; i < 3 && i < obs_fill.size(); i++) begin
      n_cmp++;
      if (obs_fill[i] !== exp_fill[i]) begin
        n_fail++; $display("FAIL abort_pix[%0d]: got %h, required %h", i, obs_fill[i], exp_fill[i]);
      end
    end
    cfg_addr = 2'd3; #1;
    n_cmp++;
    if (cfg_r_data[2:0] !== 3'b110) begin
      n_fail++; $display("FAIL abort_ctrl: got %b, required 110", cfg_r_data[2:0]);
    end
    // Start and abort together while idle: the fill runs to completion.
    program_rect(0, 0, 2, 1, 12'h777);
    clear_obs();
    step();
    cfg_w_en = 1'b1; cfg_addr = 2'd3; cfg_w_data = 32'd3;
    step();
    cfg_w_en = 1'b0;
    wait_done(20, ok);
    repeat (2) step();
    cfg_addr = 2'd3; #1;
    n_cmp++;
    if (!ok || obs_fill.size() !== 2 || cfg_r_data[2] !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_wins: got %0d writes, aborted=%b, required 2 writes, aborted=0",
                         obs_fill.size(), cfg_r_data[2]);
    end
  endtask
`else
  task automatic test_abort();
    int s; bit ok;
    program_rect(20, 5, 4, 1, 12'h321);
    clear_obs();
    start_fill(s);
    for (int i = 0; i < 20; i++) begin
      if (obs_fill.size() >= 1) break;
      step();
    end
    cfg_w_en = 1'b1; cfg_addr = 2'd3; cfg_w_data = 32'd2;
    step();
    cfg_w_en = 1'b0;
    wait_done(20, ok);
    repeat (2) step();
    cfg_addr = 2'd3; #1;
    n_cmp++;
    if (!ok || obs_fill.size() !== 4 || cfg_r_data[2] !== 1'b0) begin
      n_fail++; $display("FAIL abort_ignored: got %0d writes, bit2=%b, required 4 writes, bit2=0",
                         obs_fill.size(), cfg_r_data[2]);
    end
  endtask
`endif

  task automatic test_random();
    int s, x0, y0, w, h; bit ok;
    logic [11:0] col;
    for (int it = 0; it < 10; it++) begin
      x0 = $urandom_range(0, 410); y0 = $urandom_range(0, 305);
      w  = $urandom_range(0, 12);  h  = $urandom_range(0, 6);
      if (it % 3 == 0) begin x0 = $urandom_range(390, 399); y0 = $urandom_range(294, 299); end
      col = 12'($urandom);
      program_rect(x0, y0, w, h, col);
      build_exp(x0, y0, w, h, col);
      clear_obs();
      start_fill(s);
      ok = 1'b0;
      // Random CPU stalls and ignored register/start writes while the fill runs.
      for (int c = 0; c < 600; c++) begin
        if (done_cnt > 0) begin ok = 1'b1; break; end
        cpu_w_en = ($urandom_range(0, 3) == 0);
        if (cpu_w_en) begin
          cpu_w_addr = $urandom; cpu_w_byte_en = 4'($urandom); cpu_w_data = $urandom;
          exp_cpu.push_back({cpu_w_addr, cpu_w_byte_en, cpu_w_data});
        end
        cfg_w_en = ($urandom_range(0, 5) == 0);
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_w_data = (cfg_addr == 2'd3) ? 32'd1 : $urandom;
        step();
      end
      cpu_w_en = 1'b0; cfg_w_en = 1'b0;
      repeat (2) step();
      n_cmp++;
      if (!ok || done_cnt !== 1 || obs_fill.size() !== exp_fill.size() || obs_cpu.size() !== exp_cpu.size()) begin
        n_fail++;
        $display("FAIL rand%0d_count: got done=%0d fill=%0d cpu=%0d, required done=1 fill=%0d cpu=%0d",
                 it, done_cnt, obs_fill.size(), obs_cpu.size(), exp_fill.size(), exp_cpu.size());
      end
      for (int i = 0; i < exp_fill.size() && i < obs_fill.size(); i++) begin
        n_cmp++;
        if (obs_fill[i] !== exp_fill[i]) begin
          n_fail++; $display("FAIL rand%0d_pix[%0d]: got %h, required %h", it, i, obs_fill[i], exp_fill[i]);
        end
      end
      for (int i = 0; i < exp_cpu.size() && i < obs_cpu.size(); i++) begin
        n_cmp++;
        if (obs_cpu[i] !== exp_cpu[i]) begin
          n_fail++; $display("FAIL rand%0d_cpu[%0d]: got %h, required %h", it, i, obs_cpu[i], exp_cpu[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_clip();
    test_stall();
    test_reset_mid();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fill_engine.md
Name: vga_fill_engine

Overview:
- Hardware rectangle-fill stage directly upstream of the VGA controller's video-memory write port.
- The CPU programs the rectangle origin, size and colour through a small register port, then starts the engine.
- The engine generates one pixel write per cycle on the vga_w_* interface, clipped to the screen.
- CPU direct video-memory writes pass through with priority; while one is present the engine stalls.

Parameters:
- screen_length, 400, pixels per row.
- screen_width, 300, rows per frame.
- X_WIDTH, 11, width of x coordinates and widths.
- Y_WIDTH, 11, width of y coordinates and heights.
- VMEM_ADDR_WIDTH, 32, byte-address width of the vga_w_addr bus.
- VMEM_BASE, 0, byte address of pixel (0,0).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cfg_w_en  in  1  register write strobe.
- cfg_addr  in  2  register select: 0 ORIGIN, 1 SIZE, 2 COLOR, 3 CTRL.
- cfg_w_data  in  32  register write data.
- cfg_r_data  out  32  combinational read of the cfg_addr register.
- cpu_w_en  in  1  CPU direct vmem write strobe.
- cpu_w_addr  in  VMEM_ADDR_WIDTH  CPU write byte address.
- cpu_w_byte_en  in  4  CPU write byte enables.
- cpu_w_data  in  32  CPU write data.
- vga_w_en  out  1  registered write strobe to the VGA controller.
- vga_w_addr  out  VMEM_ADDR_WIDTH  registered byte address.
- vga_w_byte_en  out  4  registered byte enables.
- vga_w_data  out  32  registered write data.
- busy  out  1  high while a fill is running.
- done  out  1  one-cycle pulse when a fill completes, including a fill that makes zero writes.

Behaviour:
- Pixel format:
  - 16-bit halfword per pixel; colour is in bits [11:0], bits [15:12] are written 0.
  - Pixel byte address = VMEM_BASE + (y*screen_length + x)*2.
  - Even x: byte_en 4'b0011, data {16'b0, pix}.
  - Odd x: byte_en 4'b1100, data {pix, 16'b0}.
- Registers:
  - ORIGIN: x0 in [X_WIDTH-1:0], y0 in [Y_WIDTH+15:16].
  - SIZE: w in [X_WIDTH-1:0], h in [Y_WIDTH+15:16].
  - COLOR: [11:0].
  - CTRL write: bit0 = start.
  - CTRL read: bit0 = busy; bit1 = sticky done flag, cleared by start.
  - Reset values: all registers 0.
  - Writes to ORIGIN, SIZE or COLOR while busy are accepted but do not affect the running fill.
- Start and clipping:
  - On start, working copies are latched: xs = x0, xe = min(x0+w, screen_length), ys = y0, ye = min(y0+h, screen_width).
  - Sums are computed one bit wider than the field, so there is no wrap.
  - If w==0, h==0, x0>=screen_length or y0>=screen_width, the FSM goes directly to DONE and makes zero writes.
- FSM states:
  - IDLE -> RUN on start (geometry valid) or IDLE -> DONE on start (empty rectangle).
  - RUN: each cycle with cpu_w_en==0, emit pixel (x,y), then x++.
  - At x==xe-1: x = xs, y++, and the row base advances by screen_length*2 using an adder, not a multiplier.
  - After the last pixel (xe-1, ye-1): RUN -> DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - A start while in RUN or DONE is ignored.
- Arbitration:
  - cpu_w_en has absolute priority: when it is high, the output registers take the cpu_w_* values and the engine holds its position.
  - No pixel is lost or duplicated across a stall.
- Latency:
  - Outputs are registered; a CPU write appears on vga_w_* one cycle after cpu_w_en.
  - The first fill pixel appears one cycle after the start write enters RUN; a start write at cycle N gives the first vga_w_en at N+2.
  - Steady state is one pixel per cycle.
  - An unstalled W×H fill takes W*H cycles in RUN.
- Reset:
  - Any cycle with reset high returns the FSM to IDLE and aborts any fill in progress.
  - On reset: vga_w_en=0, vga_w_addr=0, vga_w_byte_en=0, vga_w_data=0, busy=0, done=0, sticky done flag=0.
- busy is 1 exactly in RUN.

Optional Feature:
- Macro: VGA_FILL_ABORT_EN.
- Defined:
  - CTRL write with bit1=1 while in RUN aborts: no further pixels are emitted and the FSM goes to DONE (done pulses).
  - CTRL read bit2 = sticky aborted flag, cleared by start.
  - Start and abort written in the same cycle while idle: start wins.
- Undefined: CTRL bit1 is ignored and read bit2 reads 0.

Test Plan:
- Reset; ORIGIN=(2,1), SIZE=(3,2), COLOR=12'hABC, start -> 6 writes to byte addresses 804,806,808,1604,1606,1608.
  - byte_en sequence 0011,1100,0011, then the same for the second row.
  - data 0x00000ABC / 0x0ABC0000; busy high for 6 cycles; one done pulse.
- ORIGIN=(398,299), SIZE=(10,10) -> clipped to 2 writes at (398,299) and (399,299), byte addresses 239996 and 239998, then done.
- SIZE=(0,5), start -> zero writes; done pulses 2 cycles after the start write; CTRL read bit1=1.
- During a 4×1 fill, assert cpu_w_en for 2 cycles after the 2nd pixel -> the CPU writes appear verbatim, then the 3rd and 4th pixels follow; 4 fill writes total.
- Assert reset mid-fill, then deassert -> all outputs are 0 and busy=0; a new start produces the full rectangle from its origin.
- With VGA_FILL_ABORT_EN: write CTRL=2 after 3 pixels of a 10×1 fill -> exactly 3 pixels written, done pulse, CTRL read bit2=1.
